cache_mem_responder: RTL and testbench
======================================

CACHE_MEM_RESPONDER -- requirements
Module: cache_mem_responder

Interface
REQ-001 SHALL have parameter WB_LAT, default 4, write-back latency in cycles (legal range 1-255).
REQ-002 SHALL have parameter RD_LAT, default 6, line-fill latency in cycles (legal range 1-255).
REQ-003 SHALL have port clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port evict  input  1  cache controller eviction pulse.
REQ-006 SHALL have port write_back  input  1  victim is dirty; qualified by evict.
REQ-007 SHALL have port allocate  input  1  fill request, held by the controller until mem_ready.
REQ-008 SHALL have port addr  input  24  CPU address; line address is addr[23:6].
REQ-009 SHALL have port mem_ready  output  1  fill complete, one-cycle pulse.
REQ-010 SHALL have port busy  output  1  high in every state except IDLE.
REQ-011 SHALL have port fill_addr  output  18  line address captured at FILL entry.
REQ-012 SHALL have port wb_count  output  8  completed write-backs, saturating.
REQ-013 SHALL have port fill_count  output  8  completed fills, saturating.
REQ-014 SHALL have port proto_err  output  1  sticky protocol-violation flag.

Function
REQ-015 SHALL implement FSM states IDLE, WB, WB_DONE, FILL, RESP; all outputs registered or decoded from the state and registers only.
REQ-016 IDLE: evict&write_back -> WB; evict&!write_back -> WB_DONE; else allocate -> FILL; else stay. evict has priority over allocate.
REQ-017 WB SHALL last exactly WB_LAT cycles (down-counter loaded with WB_LAT-1 on entry); on the last cycle, increment wb_count, then go to FILL if allocate=1, else WB_DONE.
REQ-018 WB_DONE SHALL wait indefinitely for allocate=1, then go to FILL.
REQ-019 On every FILL entry, fill_addr SHALL load addr[23:6] sampled in the transition cycle; it holds the value otherwise.
REQ-020 FILL SHALL last exactly RD_LAT cycles, then go to RESP; fill_count increments on the FILL->RESP transition.
REQ-021 If allocate=0 in any FILL cycle, the fill SHALL abort: go to IDLE, no mem_ready, no fill_count increment.
REQ-022 RESP SHALL last one cycle with mem_ready=1, then go to IDLE; mem_ready SHALL be 0 in all other states.
REQ-023 proto_err SHALL set when evict=1 in any state other than IDLE; evict SHALL otherwise be ignored outside IDLE; cleared only by reset.
REQ-024 wb_count and fill_count SHALL saturate at 255 (no wrap).
REQ-025 write_back SHALL be ignored when evict=0.

Reset
REQ-026 rst=0 SHALL immediately force state IDLE, with mem_ready, busy, proto_err, fill_addr, wb_count, fill_count and the latency counter all 0, regardless of clk.
REQ-027 Reset asserted mid-WB or mid-FILL SHALL abandon the transaction; after release, the block SHALL be in IDLE and produce no mem_ready until a new request arrives.

Verification (WB_LAT=4, RD_LAT=6, cycle 0 = request cycle)
REQ-028 Clean miss: evict=1, write_back=0 at cycle 0, allocate=1 from cycle 1 -> WB_DONE at cycle 1, FILL cycles 2-7, mem_ready=1 only at cycle 8, fill_count=1, wb_count=0.
REQ-029 Dirty miss: evict=1, write_back=1 at cycle 0, allocate=1 from cycle 1 -> WB cycles 1-4, FILL cycles 5-10, mem_ready=1 at cycle 11, wb_count=1, fill_count=1.
REQ-030 Direct fill: allocate=1, addr=24'hABCDC0 at cycle 0 -> fill_addr=18'h2AF37 from cycle 1, mem_ready=1 at cycle 7.
REQ-031 Abort: as in REQ-028, but allocate drops at cycle 4 -> IDLE at cycle 5, mem_ready never asserts, fill_count=0.
REQ-032 Protocol/saturation: evict=1 during FILL -> proto_err=1 and stays 1; 300 back-to-back dirty misses -> wb_count=fill_count=255.
REQ-033 Reset: rst=0 at cycle 3 of a dirty miss -> all outputs 0 asynchronously, busy=0, no mem_ready after release.

Source files
------------

// File: rtl/cache_mem_responder.sv
// cache_mem_responder: models memory-side write-back and line-fill timing for a cache controller
module cache_mem_responder #(
    parameter int WB_LAT = 4,
    parameter int RD_LAT = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        evict,
    input  logic        write_back,
    input  logic        allocate,
    input  logic [23:0] addr,
    output logic        mem_ready,
    output logic        busy,
    output logic [17:0] fill_addr,
    output logic [7:0]  wb_count,
    output logic [7:0]  fill_count,
    output logic        proto_err
);
    typedef enum logic [2:0] {IDLE, WB, WB_DONE, FILL, RESP} state_t;
    state_t      r_state, w_next;
    logic [7:0]  r_cnt;
    logic [17:0] r_fill_addr;
    logic [7:0]  r_wb_count, r_fill_count;
    logic        r_proto_err;
    logic        w_wb_last, w_fill_last, w_enter_wb, w_enter_fill;

    // state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_next;
    end

    // next-state logic; an allocate drop during FILL aborts before the last-cycle check
    always_comb begin
        w_next      = r_state;
        w_wb_last   = 1'b0;
        w_fill_last = 1'b0;
        case (r_state)
            IDLE:    w_next = evict ? (write_back ? WB : WB_DONE) : (allocate ? FILL : IDLE);
            WB: begin
                if (r_cnt == '0) begin
                    w_wb_last = 1'b1;
                    w_next    = allocate ? FILL : WB_DONE;
                end
            end
            WB_DONE: w_next = allocate ? FILL : WB_DONE;
            FILL: begin
                if (!allocate) w_next = IDLE;
                else if (r_cnt == '0) begin
                    w_fill_last = 1'b1;
                    w_next      = RESP;
                end
            end
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
        w_enter_wb   = (w_next == WB) && (r_state != WB);
        w_enter_fill = (w_next == FILL) && (r_state != FILL);
    end

    // latency counter, captured fill address, saturating counters and sticky error
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt        <= '0;
            r_fill_addr  <= '0;
            r_wb_count   <= '0;
            r_fill_count <= '0;
            r_proto_err  <= 1'b0;
        end else begin
            if (w_enter_wb)         r_cnt <= 8'(WB_LAT - 1);
            else if (w_enter_fill)  r_cnt <= 8'(RD_LAT - 1);
            else if (r_cnt != '0)   r_cnt <= r_cnt - 8'd1;
            if (w_enter_fill) r_fill_addr <= addr[23:6];
            if (w_wb_last && r_wb_count != 8'hFF)     r_wb_count   <= r_wb_count + 8'd1;
            if (w_fill_last && r_fill_count != 8'hFF) r_fill_count <= r_fill_count + 8'd1;
            if (evict && r_state != IDLE) r_proto_err <= 1'b1;
        end
    end

    assign mem_ready  = (r_state == RESP);
    assign busy       = (r_state != IDLE);
    assign fill_addr  = r_fill_addr;
    assign wb_count   = r_wb_count;
    assign fill_count = r_fill_count;
    assign proto_err  = r_proto_err;
endmodule

// File: tb/tb_cache_mem_responder.sv
// tb_cache_mem_responder: directed checks of miss timing, aborts, protocol errors, saturation and reset
module tb_cache_mem_responder;
    logic        clk, rst, evict, write_back, allocate;
    logic [23:0] addr;
    logic        mem_ready, busy, proto_err;
    logic [17:0] fill_addr;
    logic [7:0]  wb_count, fill_count;
    int          n_tests = 0, n_fail = 0, cyc = 0;
    int          first, pulses, timeouts;
    logic        got;

    cache_mem_responder #(.WB_LAT(4), .RD_LAT(6)) dut (
        .clk(clk), .rst(rst), .evict(evict), .write_back(write_back),
        .allocate(allocate), .addr(addr), .mem_ready(mem_ready), .busy(busy),
        .fill_addr(fill_addr), .wb_count(wb_count), .fill_count(fill_count),
        .proto_err(proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic watch(input int n, output int f, output int p);
        f = -1;
        p = 0;
        for (int k = 0; k < n; k++) begin
            step();
            if (mem_ready) begin
                p++;
                if (f < 0) f = cyc;
                allocate = 1'b0;
            end
        end
    endtask

    initial begin
        rst = 1'b0; evict = 1'b0; write_back = 1'b0; allocate = 1'b0; addr = '0;
        #3;
        check("rst_busy", busy, 0);
        check("rst_ready", mem_ready, 0);
        check("rst_err", proto_err, 0);
        check("rst_faddr", fill_addr, 0);
        check("rst_wbc", wb_count, 0);
        check("rst_fc", fill_count, 0);
        step(); step();
        rst = 1'b1;
        step();

        // write_back alone is ignored
        write_back = 1'b1;
        step();
        check("wb_ignored", busy, 0);
        write_back = 1'b0;

        // clean miss
        cyc = 0; evict = 1'b1; write_back = 1'b0; allocate = 1'b1; addr = 24'h123440;
        step();
        evict = 1'b0;
        check("clean_c1_busy", busy, 1);
        check("clean_c1_ready", mem_ready, 0);
        watch(11, first, pulses);
        check("clean_ready_cyc", first, 8);
        check("clean_pulses", pulses, 1);
        check("clean_fc", fill_count, 1);
        check("clean_wbc", wb_count, 0);
        check("clean_idle", busy, 0);

        // dirty miss
        cyc = 0; evict = 1'b1; write_back = 1'b1; allocate = 1'b1;
        step();
        evict = 1'b0; write_back = 1'b0;
        step(); step(); step();
        check("dirty_c4_wbc", wb_count, 0);
        step();
        check("dirty_c5_wbc", wb_count, 1);
        watch(8, first, pulses);
        check("dirty_ready_cyc", first, 11);
        check("dirty_pulses", pulses, 1);
        check("dirty_fc", fill_count, 2);

        // direct fill with address capture
        cyc = 0; allocate = 1'b1; addr = 24'hABCDC0;
        step();
        check("direct_faddr", fill_addr, 18'h2AF37);
        addr = 24'hFFFFFF;
        step(); step();
        check("direct_faddr_hold", fill_addr, 18'h2AF37);
        watch(6, first, pulses);
        check("direct_ready_cyc", first, 7);
        check("direct_fc", fill_count, 3);

        // abort during fill
        cyc = 0; evict = 1'b1; allocate = 1'b1;
        step();
        evict = 1'b0;
        step(); step(); step();
        allocate = 1'b0;
        step();
        check("abort_idle", busy, 0);
        watch(10, first, pulses);
        check("abort_pulses", pulses, 0);
        check("abort_fc", fill_count, 3);
        check("abort_err", proto_err, 0);

        // evict during fill: flagged, otherwise ignored
        cyc = 0; allocate = 1'b1; addr = 24'h000040;
        step(); step();
        evict = 1'b1;
        step();
        evict = 1'b0;
        check("proto_err_set", proto_err, 1);
        check("proto_busy", busy, 1);
        watch(6, first, pulses);
        check("proto_ready_cyc", first, 7);
        check("proto_fc", fill_count, 4);
        step(); step();
        check("proto_err_sticky", proto_err, 1);

        // asynchronous reset in the middle of a dirty miss
        cyc = 0; evict = 1'b1; write_back = 1'b1; allocate = 1'b1;
        step();
        evict = 1'b0; write_back = 1'b0;
        step(); step();
        #2 rst = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_ready", mem_ready, 0);
        check("arst_err", proto_err, 0);
        check("arst_faddr", fill_addr, 0);
        check("arst_wbc", wb_count, 0);
        check("arst_fc", fill_count, 0);
        allocate = 1'b0;
        step(); step();
        rst = 1'b1;
        watch(15, first, pulses);
        check("arst_no_ready", pulses, 0);
        check("arst_idle", busy, 0);

        // saturation over 300 back-to-back dirty misses
        timeouts = 0;
        for (int i = 0; i < 300; i++) begin
            evict = 1'b1; write_back = 1'b1; allocate = 1'b1;
            step();
            evict = 1'b0; write_back = 1'b0;
            got = 1'b0;
            for (int k = 0; k < 20 && !got; k++) begin
                step();
                if (mem_ready) got = 1'b1;
            end
            allocate = 1'b0;
            step();
            if (!got) timeouts++;
        end
        check("sat_timeouts", timeouts, 0);
        check("sat_wbc", wb_count, 255);
        check("sat_fc", fill_count, 255);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
